// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller.
// Walks a fetch PC through a small instruction ROM and presents each word on a
// valid/ready output slot. Supports redirects, halts on ebreak once it has been
// accepted downstream, and faults on a misaligned or out-of-range fetch PC.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | first cycle after reset, no capture
// FETCH  | normal streaming: capture ROM word whenever the slot is free
// DRAIN  | ebreak captured, fetch stopped, waiting for it to be accepted
// HALT   | ebreak accepted downstream, terminal until reset
// FAULT  | fetch PC was misaligned or outside the ROM, terminal until reset
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter int unsigned ROM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        halt,
  output logic        fault,
  output logic [31:0] fetch_cnt
);

  localparam logic [31:0] EBREAK    = 32'h0010_0073;
  localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS) << 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    HALT,
    FAULT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_offset;
  logic        pc_legal;
  logic        handshake;
  logic        slot_free;

  // The ROM is addressed straight from the PC register.
  assign inst_addr = pc;

  // Offset arithmetic wraps, so anything below RESET_PC lands far above the
  // ROM window and is rejected by the single unsigned compare.
  assign pc_offset = pc - RESET_PC;
  assign pc_legal  = (pc[1:0] == 2'b00) && (pc_offset < ROM_BYTES);

  assign handshake = out_valid & out_ready;
  assign slot_free = ~out_valid | handshake;

  // Fetch sequencing FSM with registered output slot, status flags and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_pc    <= '0;
      halt      <= 1'b0;
      fault     <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      // Acceptance is counted even when a redirect flushes the slot afterwards.
      if (handshake) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end

      case (state)
        IDLE: begin
          state <= FETCH;
        end

        FETCH: begin
          if (redirect_valid) begin
            pc        <= redirect_pc;
            out_valid <= 1'b0;
          end else if (!pc_legal) begin
            fault     <= 1'b1;
            out_valid <= 1'b0;
            state     <= FAULT;
          end else if (slot_free) begin
            out_inst  <= inst_data;
            out_pc    <= pc;
            out_valid <= 1'b1;
            pc        <= pc + 32'd4;
            if (inst_data == EBREAK) begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (redirect_valid) begin
            pc        <= redirect_pc;
            out_valid <= 1'b0;
            state     <= FETCH;
          end else if (handshake) begin
            out_valid <= 1'b0;
            halt      <= 1'b1;
            state     <= HALT;
          end
        end

        HALT, FAULT: begin
          // Terminal: only reset leaves these states.
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios plus randomized
// traffic, compared every cycle against a transaction-level reference model.
module tb_inst_fetch_ctrl;

  localparam logic [31:0] RPC    = 32'h8000_0000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        halt;
  logic        fault;
  logic [31:0] fetch_cnt;

  always #5 clk = ~clk;

  inst_fetch_ctrl #(.RESET_PC(RPC), .ROM_WORDS(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_addr      (inst_addr),
    .inst_data      (inst_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .halt           (halt),
    .fault          (fault),
    .fetch_cnt      (fetch_cnt)
  );

  // ROM image: 32 words at RPC, a fixed pattern elsewhere.
  logic [31:0] rom [32];
  logic [31:0] rom_off;
  assign rom_off   = inst_addr - RPC;
  assign inst_data = (rom_off < 32'd128) ? rom[rom_off[6:2]] : 32'hDEAD_BEEF;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - RPC;
    if (off < 32'd128) return rom[off[6:2]];
    return 32'hDEAD_BEEF;
  endfunction

  // Distinct words (unique top byte); optional ebreaks sprinkled in.
  task automatic fill_rom(input int ebreak_pct);
    for (int i = 0; i < 32; i++) begin
      rom[i] = {8'(i + 1), 24'($urandom)};
      if (ebreak_pct > 0 && ($urandom % 100) < ebreak_pct) rom[i] = EBREAK;
    end
  endtask

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Reference model: PC, one output slot, terminal flags, accept counter.
  // "Draining" is simply an ebreak sitting in the slot.
  logic [31:0] m_pc, m_si, m_sp, m_cnt;
  logic        m_sv, m_started, m_halted, m_faulted;

  task automatic model_step();
    logic hs, draining, legal;
    if (rst) begin
      m_pc = RPC; m_sv = 0; m_si = 0; m_sp = 0; m_cnt = 0;
      m_started = 0; m_halted = 0; m_faulted = 0;
      return;
    end
    if (!m_started) begin
      m_started = 1;
      return;
    end
    if (m_halted || m_faulted) return;
    hs       = m_sv && out_ready;
    draining = m_sv && (m_si == EBREAK);
    legal    = (m_pc[1:0] == 2'b00) && ((m_pc - RPC) < 32'd128);
    if (hs) m_cnt = m_cnt + 1;
    if (redirect_valid) begin
      m_pc = redirect_pc;
      m_sv = 0;
    end else if (draining) begin
      if (hs) begin
        m_sv = 0;
        m_halted = 1;
      end
    end else if (!legal) begin
      m_faulted = 1;
      m_sv = 0;
    end else if (!m_sv || hs) begin
      m_si = rom_word(m_pc);
      m_sp = m_pc;
      m_sv = 1;
      m_pc = m_pc + 4;
    end
  endtask

  task automatic compare_all();
    check_eq("inst_addr", inst_addr, m_pc);
    check_eq("out_valid", {31'b0, out_valid}, {31'b0, m_sv});
    check_eq("out_inst",  out_inst,  m_si);
    check_eq("out_pc",    out_pc,    m_sp);
    check_eq("halt",      {31'b0, halt},  {31'b0, m_halted});
    check_eq("fault",     {31'b0, fault}, {31'b0, m_faulted});
    check_eq("fetch_cnt", fetch_cnt, m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset(input int n);
    rst = 1; redirect_valid = 0;
    repeat (n) tick();
    rst = 0;
  endtask

  initial begin
    rst = 1; redirect_valid = 0; redirect_pc = 0; out_ready = 0;
    fill_rom(0);
    @(negedge clk);

    // Streaming with constant ready.
    out_ready = 1;
    do_reset(2);
    tick();
    check_eq("idle_no_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check_eq("first_valid_pc", out_pc, RPC);
    repeat (10) tick();

    // Backpressure: hold for 3 cycles after first valid.
    out_ready = 0;
    do_reset(1);
    for (int k = 0; k < 5 && !m_sv; k++) tick();
    check_eq("bp_first_pc", out_pc, RPC);
    repeat (3) tick();
    check_eq("bp_pc_held", inst_addr, RPC + 32'd4);
    check_eq("bp_pc_out", out_pc, RPC);
    out_ready = 1;
    repeat (8) tick();

    // Redirect coinciding with a handshake at RPC+4.
    do_reset(1);
    for (int k = 0; k < 8 && !(m_sv && m_sp == RPC + 32'd4); k++) tick();
    check_eq("rd_wait_pc", out_pc, RPC + 32'd4);
    redirect_valid = 1; redirect_pc = RPC + 32'h10;
    tick();
    redirect_valid = 0;
    check_eq("rd_cnt", fetch_cnt, 32'd2);
    tick();
    check_eq("rd_new_pc", out_pc, RPC + 32'h10);
    repeat (4) tick();

    // Misaligned redirect faults.
    do_reset(1);
    repeat (3) tick();
    redirect_valid = 1; redirect_pc = RPC + 32'h2;
    tick();
    redirect_valid = 0;
    repeat (2) tick();
    check_eq("mis_fault", {31'b0, fault}, 32'd1);
    redirect_valid = 1; redirect_pc = RPC;
    repeat (3) tick();
    redirect_valid = 0;

    // Streaming off the end of the ROM.
    do_reset(1);
    repeat (40) tick();
    check_eq("end_fault", {31'b0, fault}, 32'd1);
    check_eq("end_pc", inst_addr, RPC + 32'h80);

    // Halt on ebreak at RPC+0xC with backpressure, then reset out of HALT.
    rom[3] = EBREAK;
    do_reset(1);
    for (int k = 0; k < 10 && !(m_sv && m_sp == RPC + 32'hC); k++) tick();
    check_eq("eb_pc", out_pc, RPC + 32'hC);
    out_ready = 0;
    repeat (2) tick();
    check_eq("eb_held", {31'b0, out_valid}, 32'd1);
    check_eq("eb_frozen", inst_addr, RPC + 32'h10);
    out_ready = 1;
    tick();
    check_eq("eb_halt", {31'b0, halt}, 32'd1);
    redirect_valid = 1; redirect_pc = RPC;
    repeat (3) tick();
    redirect_valid = 0;
    check_eq("eb_ignore", {31'b0, halt}, 32'd1);
    do_reset(1);
    check_eq("rst_cnt", fetch_cnt, 32'd0);
    repeat (6) tick();

    // Randomized traffic.
    for (int r = 0; r < 6; r++) begin
      fill_rom(5);
      do_reset(1 + int'($urandom % 2));
      for (int c = 0; c < 80; c++) begin
        out_ready      = ($urandom % 10) < 7;
        redirect_valid = ($urandom % 20) == 0;
        case ($urandom % 4)
          0: redirect_pc = RPC + 32'h2;
          1: redirect_pc = RPC + 32'h100;
          default: redirect_pc = RPC + 4 * ($urandom % 32);
        endcase
        rst = ($urandom % 100) == 0;
        tick();
      end
      rst = 0; redirect_valid = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter ROM_WORDS, default 32, the number of valid ROM words starting at RESET_PC.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port inst_addr  out  32  fetch address to the instruction ROM.
REQ-006 SHALL have port inst_data  in  32  ROM read data, combinational from inst_addr in the same cycle.
REQ-007 SHALL have port redirect_valid  in  1  request to change the fetch PC.
REQ-008 SHALL have port redirect_pc  in  32  new fetch PC, sampled when redirect_valid=1.
REQ-009 SHALL have port out_valid  out  1  out_inst/out_pc hold a fetched instruction.
REQ-010 SHALL have port out_ready  in  1  downstream accepts the instruction this cycle.
REQ-011 SHALL have port out_inst  out  32  fetched instruction word.
REQ-012 SHALL have port out_pc  out  32  address of out_inst.
REQ-013 SHALL have port halt  out  1  sticky: an ebreak (32'h0010_0073) was accepted downstream.
REQ-014 SHALL have port fault  out  1  sticky: the fetch PC was misaligned or out of ROM range.
REQ-015 SHALL have port fetch_cnt  out  32  count of instructions accepted downstream; wraps 0xFFFF_FFFF->0.

Function
REQ-016 SHALL implement states IDLE, FETCH, DRAIN, HALT, FAULT.
REQ-017 SHALL drive inst_addr = pc at all times; pc is an internal 32-bit register.
REQ-018 SHALL define handshake as out_valid & out_ready; out_inst/out_pc SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 SHALL move IDLE->FETCH unconditionally one cycle after reset deasserts; no capture occurs in IDLE.
REQ-020 SHALL, in FETCH, with slot free (out_valid=0 or handshake), redirect_valid=0 and pc legal: load out_inst<=inst_data, out_pc<=pc, out_valid<=1, pc<=pc+4 (mod 2^32).
REQ-021 SHALL, in FETCH, with slot occupied and no handshake, hold pc and the output registers.
REQ-022 SHALL treat pc as legal iff pc[1:0]==0 and (pc-RESET_PC) < 4*ROM_WORDS (unsigned, 32-bit).
REQ-023 SHALL, in FETCH with illegal pc and no redirect, enter FAULT: fault<=1, out_valid<=0, no capture.
REQ-024 SHALL give redirect_valid priority in FETCH and DRAIN: pc<=redirect_pc, out_valid<=0 (flush) next cycle, no capture that cycle, state FETCH; a handshake in the same cycle SHALL still count as accepted.
REQ-025 SHALL, on capture of 32'h0010_0073, enter DRAIN and stop fetching (pc frozen at ebreak_pc+4).
REQ-026 SHALL, in DRAIN, on handshake of the ebreak: out_valid<=0, halt<=1, state HALT.
REQ-027 SHALL ignore redirect_valid and out_ready in HALT and FAULT; both are terminal until rst.
REQ-028 SHALL increment fetch_cnt by 1 on every handshake, in any state.
REQ-029 SHALL produce the first out_valid=1 in the second cycle after reset deasserts (IDLE cycle, then FETCH capture).

Reset
REQ-030 SHALL, while rst=1, set pc=RESET_PC, state=IDLE, out_valid=0, out_inst=0, out_pc=0, halt=0, fault=0, fetch_cnt=0.
REQ-031 SHALL abort any state, including HALT, FAULT and DRAIN, when rst is asserted mid-operation, with no handshake counted in that cycle.

Verification
REQ-032 SHALL cover streaming: out_ready=1 constantly, ROM words distinct -> out_pc 0x8000_0000, 0x8000_0004, ... one per cycle from cycle 2; fetch_cnt tracks handshakes.
REQ-033 SHALL cover backpressure: out_ready=0 for 3 cycles after the first valid -> out_inst/out_pc stable, pc stays 0x8000_0004, then resumes without skip or duplicate.
REQ-034 SHALL cover redirect with simultaneous handshake: redirect_pc=0x8000_0010 while handshake at 0x8000_0004 -> fetch_cnt+1, next valid out_pc=0x8000_0010, 0x8000_0008 never issued.
REQ-035 SHALL cover faults: redirect_pc=0x8000_0002 -> fault=1, out_valid=0; separately, streaming past 0x8000_007C -> fault=1 when pc=0x8000_0080.
REQ-036 SHALL cover halt: ebreak at 0x8000_000C, out_ready=0 for 2 cycles -> out_valid held, no new fetch, halt=1 the cycle after acceptance; later redirect ignored.
REQ-037 SHALL cover reset mid-stream: rst=1 for one cycle in HALT -> all outputs return to REQ-030 values and streaming restarts at 0x8000_0000.
